toggle_bank_arbiter: RTL and testbench



---
 rtl/toggle_bank_arbiter.sv | 120 ++++++++++++
 tb/tb_toggle_bank_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one WIDTH-bit bank of toggle flip-flops.
// Optional synchronous bank clear (input clr) is enabled by defining TOGGLE_BANK_ARBITER_CLEAR_EN.
module toggle_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
    input  logic                  clr,
`endif
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] mask,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      state,
    output logic                  busy,
    output logic [CNT_W-1:0]      grant_cnt
);
    localparam int PTR_W = $clog2(NREQ);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } fsm_t;

    fsm_t              fsm_r;
    logic [PTR_W-1:0]  ptr_r;
    logic [NREQ-1:0]   gnt_r;
    logic [WIDTH-1:0]  state_r;
    logic              busy_r;
    logic [CNT_W-1:0]  grant_cnt_r;

    logic [WIDTH-1:0]  mask_arr_s [NREQ];
    logic [PTR_W-1:0]  cand_s;
    logic [PTR_W-1:0]  winner_s;
    logic              found_s;
    logic [WIDTH-1:0]  win_mask_s;
    logic [PTR_W-1:0]  next_ptr_s;
    logic              clr_s;

`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
    assign clr_s = clr;
`else
    assign clr_s = 1'b0;
`endif

    // Unpack the flat mask bus into one word per requester.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            mask_arr_s[i] = mask[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search starting at ptr, wrapping NREQ-1 -> 0; first hit wins.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {PTR_W{1'b0}};
        cand_s   = {PTR_W{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = PTR_W'((int'(ptr_r) + k) % NREQ);
            if (!found_s && req[cand_s]) begin
                found_s  = 1'b1;
                winner_s = cand_s;
            end else begin
                winner_s = winner_s;
            end
        end
        win_mask_s = mask_arr_s[winner_s];
        next_ptr_s = (winner_s == PTR_W'(NREQ - 1)) ? {PTR_W{1'b0}} : winner_s + 1'b1;
    end

    // Two-state grant FSM; S_ACK always lasts one cycle, so throughput is one grant per two cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r       <= S_IDLE;
            ptr_r       <= {PTR_W{1'b0}};
            gnt_r       <= {NREQ{1'b0}};
            state_r     <= {WIDTH{1'b0}};
            busy_r      <= 1'b0;
            grant_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (fsm_r)
                S_IDLE: begin
                    if (clr_s) begin
                        state_r <= {WIDTH{1'b0}};
                        gnt_r   <= {NREQ{1'b0}};
                        busy_r  <= 1'b0;
                    end else if (found_s) begin
                        gnt_r       <= {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
                        state_r     <= state_r ^ win_mask_s;
                        ptr_r       <= next_ptr_s;
                        grant_cnt_r <= grant_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        busy_r      <= 1'b1;
                        fsm_r       <= S_ACK;
                    end else begin
                        gnt_r  <= {NREQ{1'b0}};
                        busy_r <= 1'b0;
                    end
                end
                S_ACK: begin
                    gnt_r  <= {NREQ{1'b0}};
                    busy_r <= 1'b0;
                    fsm_r  <= S_IDLE;
                end
                default: begin
                    gnt_r  <= {NREQ{1'b0}};
                    busy_r <= 1'b0;
                    fsm_r  <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign state     = state_r;
    assign busy      = busy_r;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Self-checking bench for toggle_bank_arbiter: per-cycle model compare plus directed literal checks.
`timescale 1ns/1ps
module tb_toggle_bank_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic                  clk  = 1'b0;
    logic                  rst  = 1'b1;
    logic                  clr  = 1'b0;
    logic [NREQ-1:0]       req  = '0;
    logic [NREQ*WIDTH-1:0] mask = '0;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      state;
    logic                  busy;
    logic [CNT_W-1:0]      grant_cnt;

    int errors = 0;
    int checks = 0;
    bit auto_drop = 1'b1;
    bit check_en  = 1'b0;

    logic [WIDTH-1:0] m_state;
    logic [NREQ-1:0]  m_gnt;
    logic             m_busy;
    logic [CNT_W-1:0] m_cnt;
    int               m_ptr;
    bit               m_ack;

    toggle_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        .clr       (clr),
`endif
        .req       (req),
        .mask      (mask),
        .gnt       (gnt),
        .state     (state),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a grant phase always followed by a one-cycle acknowledge phase.
    always @(posedge clk or posedge rst) begin : model
        int w;
        if (rst) begin
            m_state <= '0; m_gnt <= '0; m_busy <= 1'b0; m_cnt <= '0; m_ptr <= 0; m_ack <= 1'b0;
        end else if (m_ack) begin
            m_ack <= 1'b0; m_gnt <= '0; m_busy <= 1'b0;
        end else if (clr) begin
            m_state <= '0;
        end else if (req != '0) begin
            w = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            m_gnt   <= NREQ'(1) << w;
            m_state <= m_state ^ mask[w*WIDTH +: WIDTH];
            m_ptr   <= (w + 1) % NREQ;
            m_cnt   <= m_cnt + 1'b1;
            m_busy  <= 1'b1;
            m_ack   <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, compare all outputs with the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_gnt",   32'(gnt),       32'(m_gnt));
            chk("cyc_state", 32'(state),     32'(m_state));
            chk("cyc_busy",  32'(busy),      32'(m_busy));
            chk("cyc_cnt",   32'(grant_cnt), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~gnt;
    endtask

    task automatic set_mask(input int i, input logic [WIDTH-1:0] v);
        mask[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic expect_grant(input string name, input logic [NREQ-1:0] eg,
                                input logic [WIDTH-1:0] es, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 20);
        chk({name, "_gnt"},   32'(gnt),   32'(eg));
        chk({name, "_state"}, 32'(state), 32'(es));
    endtask

    task automatic do_reset();
        req = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : stim
        int n;
        // Test 1: reset with random activity on the inputs
        req  = 4'($urandom());
        mask = $urandom();
        tick();
        check_en = 1'b1;
        repeat (2) begin
            req  = 4'($urandom());
            mask = $urandom();
            tick();
        end
        chk("rst_state", 32'(state), 32'h0);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        chk("rst_cnt",   32'(grant_cnt), 32'h0);
        req = '0;
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_state", 32'(state), 32'h0);
        chk("idle_cnt",   32'(grant_cnt), 32'h0);

        // Test 2: single requester, toggling the same mask twice
        mask = 32'hC3A5_5A00;
        set_mask(0, 8'h0F);
        req = 4'b0001;
        expect_grant("t2a", 4'b0001, 8'h0F, n);
        chk("t2a_busy", 32'(busy), 32'h1);
        tick();
        chk("t2a_gnt_drop", 32'(gnt), 32'h0);
        req = 4'b0001;
        expect_grant("t2b", 4'b0001, 8'h00, n);
        chk("t2_cnt", 32'(grant_cnt), 32'h2);

        // Test 3: all four request, each drops on its own grant
        do_reset();
        set_mask(0, 8'h01); set_mask(1, 8'h02); set_mask(2, 8'h04); set_mask(3, 8'h08);
        req = 4'b1111;
        expect_grant("t3_0", 4'b0001, 8'h01, n);
        chk("t3_lat", 32'(n), 32'h1);
        expect_grant("t3_1", 4'b0010, 8'h03, n);
        chk("t3_gap1", 32'(n), 32'h2);
        expect_grant("t3_2", 4'b0100, 8'h07, n);
        chk("t3_gap2", 32'(n), 32'h2);
        expect_grant("t3_3", 4'b1000, 8'h0F, n);
        chk("t3_cnt", 32'(grant_cnt), 32'h4);

        // Test 4: req0 and req2 held continuously alternate
        do_reset();
        auto_drop = 1'b0;
        set_mask(0, 8'h01); set_mask(1, 8'hFF); set_mask(2, 8'h04); set_mask(3, 8'hF0);
        req = 4'b0101;
        expect_grant("t4_a", 4'b0001, 8'h01, n);
        expect_grant("t4_b", 4'b0100, 8'h05, n);
        expect_grant("t4_c", 4'b0001, 8'h04, n);
        expect_grant("t4_d", 4'b0100, 8'h00, n);
        req = '0;
        auto_drop = 1'b1;
        tick();

        // Zero mask still grants and counts
        set_mask(3, 8'h3C);
        req = 4'b1000;
        expect_grant("mz_a", 4'b1000, 8'h3C, n);
        set_mask(3, 8'h00);
        req = 4'b1000;
        expect_grant("mz_b", 4'b1000, 8'h3C, n);
        chk("mz_cnt", 32'(grant_cnt), 32'h6);

        // grant_cnt wrap at 2^CNT_W
        do_reset();
        set_mask(0, 8'h00);
        for (int g = 0; g < 17; g++) begin
            req = 4'b0001;
            expect_grant("wrap", 4'b0001, 8'h00, n);
            if (g == 15) chk("wrap_zero", 32'(grant_cnt), 32'h0);
        end
        chk("wrap_one", 32'(grant_cnt), 32'h1);

        // Test 5: async reset in the middle of an acknowledge cycle
        do_reset();
        set_mask(1, 8'h66);
        req = 4'b0010;
        expect_grant("t5_pre", 4'b0010, 8'h66, n);
        #2 rst = 1'b1;
        #1;
        chk("t5_gnt",   32'(gnt),   32'h0);
        chk("t5_busy",  32'(busy),  32'h0);
        chk("t5_state", 32'(state), 32'h0);
        chk("t5_cnt",   32'(grant_cnt), 32'h0);
        rst = 1'b0;
        set_mask(0, 8'h11); set_mask(3, 8'h88);
        req = 4'b1001;
        expect_grant("t5_ptr0", 4'b0001, 8'h11, n);
        expect_grant("t5_next", 4'b1000, 8'h99, n);

`ifdef TOGGLE_BANK_ARBITER_CLEAR_EN
        // Test 6: clear wins over a request in the same idle cycle
        do_reset();
        set_mask(0, 8'hA5);
        req = 4'b0001;
        expect_grant("t6_pre", 4'b0001, 8'hA5, n);
        tick();
        clr = 1'b1;
        req = 4'b0001;
        set_mask(0, 8'h3C);
        tick();
        chk("t6_clr_state", 32'(state), 32'h0);
        chk("t6_clr_gnt",   32'(gnt),   32'h0);
        clr = 1'b0;
        tick();
        chk("t6_gnt",   32'(gnt),   32'h1);
        chk("t6_state", 32'(state), 32'h3C);
`endif

        repeat (3) tick();
        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
